// File: rtl/wb_port_scheduler.sv
// Merges ALU and load writeback results onto the single register-file write port, deferring collisions into a FIFO.
// Latency: 1 cycle for uncontested results, 1 + queue position for deferred ones. stall is high while the queue is full.
// Backpressure: valids presented while stall is high are discarded and set sticky ovf. Optional forwarding is enabled by WB_BYPASS_EN.
module wb_port_scheduler #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int QDEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alu_valid,
  input  logic [AW-1:0]             alu_rd,
  input  logic [XLEN-1:0]           alu_data,
  input  logic                      mem_valid,
  input  logic [AW-1:0]             mem_rd,
  input  logic [XLEN-1:0]           mem_data,
`ifdef WB_BYPASS_EN
  input  logic [AW-1:0]             rs1_addr,
  input  logic [AW-1:0]             rs2_addr,
  output logic                      rs1_hit,
  output logic                      rs2_hit,
  output logic [XLEN-1:0]           rs1_data,
  output logic [XLEN-1:0]           rs2_data,
`endif
  output logic                      wb_we,
  output logic [AW-1:0]             wb_rd,
  output logic [XLEN-1:0]           wb_data,
  output logic                      stall,
  output logic [$clog2(QDEPTH):0]   pend_cnt,
  output logic                      ovf
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] dat;
  } wb_ent_t;

  wb_ent_t         r_q [QDEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_cnt;
  logic            r_wb_we;
  logic [AW-1:0]   r_wb_rd;
  logic [XLEN-1:0] r_wb_dat;
  logic            r_ovf;

  logic            w_stall;
  logic            w_q_v;
  logic            w_alu_v;
  logic            w_mem_v;
  wb_ent_t         w_alu_e;
  wb_ent_t         w_mem_e;
  logic            w_sel_v;
  wb_ent_t         w_sel;
  logic            w_p0_v;
  logic            w_p1_v;
  wb_ent_t         w_p0;
  wb_ent_t         w_p1;
  logic [CW-1:0]   w_npush;
  logic [PW-1:0]   w_tail1;

  assign w_stall = (r_cnt == CW'(QDEPTH));
  assign w_q_v   = (r_cnt != '0);

  // x0 writes are dropped, and a load superseded by a same-cycle ALU write to the same rd never retires.
  assign w_alu_v = alu_valid && (alu_rd != '0) && !w_stall;
  assign w_mem_v = mem_valid && (mem_rd != '0) && !w_stall && !(w_alu_v && (mem_rd == alu_rd));
  assign w_alu_e = '{rd: alu_rd, dat: alu_data};
  assign w_mem_e = '{rd: mem_rd, dat: mem_data};

  // Age order is queue head, then mem, then alu. The oldest candidate retires and the rest go to the tail.
  always_comb begin
    w_sel_v = 1'b0;
    w_sel   = r_q[r_head];
    w_p0_v  = 1'b0;
    w_p0    = w_mem_e;
    w_p1_v  = 1'b0;
    w_p1    = w_alu_e;
    if (w_q_v) begin
      w_sel_v = 1'b1;
      if (w_mem_v) begin
        w_p0_v = 1'b1;
        w_p1_v = w_alu_v;
      end else if (w_alu_v) begin
        w_p0_v = 1'b1;
        w_p0   = w_alu_e;
      end
    end else if (w_mem_v) begin
      w_sel_v = 1'b1;
      w_sel   = w_mem_e;
      w_p0_v  = w_alu_v;
      w_p0    = w_alu_e;
    end else if (w_alu_v) begin
      w_sel_v = 1'b1;
      w_sel   = w_alu_e;
    end
  end

  assign w_npush = CW'(w_p0_v) + CW'(w_p1_v);
  assign w_tail1 = r_tail + PW'(1);

  always_ff @(posedge clk) begin
    if (w_p0_v) r_q[r_tail]  <= w_p0;
    if (w_p1_v) r_q[w_tail1] <= w_p1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_we  <= 1'b0;
      r_wb_rd  <= '0;
      r_wb_dat <= '0;
      r_cnt    <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_wb_we <= w_sel_v;
      if (w_sel_v) begin
        r_wb_rd  <= w_sel.rd;
        r_wb_dat <= w_sel.dat;
      end
      r_cnt  <= r_cnt + w_npush - CW'(w_q_v);
      r_head <= r_head + PW'(w_q_v);
      r_tail <= r_tail + PW'(w_npush);
      if (w_stall && (alu_valid || mem_valid)) r_ovf <= 1'b1;
    end
  end

  assign wb_we    = r_wb_we;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_dat;
  assign stall    = w_stall;
  assign pend_cnt = r_cnt;
  assign ovf      = r_ovf;

`ifdef WB_BYPASS_EN
  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] dat;
  } byp_t;

  // The wb register is older than every queued entry, so queue hits scanned head-to-tail override it.
  function automatic byp_t lookup(input logic [AW-1:0] addr);
    byp_t res;
    res = '0;
    if (addr != '0) begin
      if (r_wb_we && (r_wb_rd == addr)) res = '{hit: 1'b1, dat: r_wb_dat};
      for (int k = 0; k < QDEPTH; k++) begin
        logic [PW-1:0] idx;
        idx = r_head + PW'(k);
        if ((CW'(k) < r_cnt) && (r_q[idx].rd == addr)) res = '{hit: 1'b1, dat: r_q[idx].dat};
      end
    end
    return res;
  endfunction

  byp_t w_byp1;
  byp_t w_byp2;

  always_comb begin
    w_byp1 = lookup(rs1_addr);
    w_byp2 = lookup(rs2_addr);
  end

  assign rs1_hit  = w_byp1.hit;
  assign rs1_data = w_byp1.dat;
  assign rs2_hit  = w_byp2.hit;
  assign rs2_data = w_byp2.dat;
`endif

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Randomized and directed bench for wb_port_scheduler, checked against a queue-based reference model.
module tb_wb_port_scheduler;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int QD   = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alu_valid, mem_valid;
  logic [AW-1:0]   alu_rd, mem_rd;
  logic [XLEN-1:0] alu_data, mem_data;
  logic            wb_we, stall, ovf;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [$clog2(QD):0] pend_cnt;

  always #5 clk = ~clk;

  wb_port_scheduler #(.XLEN(XLEN), .AW(AW), .QDEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .pend_cnt(pend_cnt), .ovf(ovf)
  );

  typedef struct {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] dat;
  } ent_t;

  ent_t            mq[$];
  logic            e_we;
  logic [AW-1:0]   e_rd;
  logic [XLEN-1:0] e_dat;
  logic            e_ovf;
  int              n_chk = 0;
  int              n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    e_we  = 1'b0;
    e_rd  = '0;
    e_dat = '0;
    e_ovf = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".we"},    32'(wb_we),    32'(e_we));
    chk({tag, ".rd"},    32'(wb_rd),    32'(e_rd));
    chk({tag, ".data"},  wb_data,       e_dat);
    chk({tag, ".cnt"},   32'(pend_cnt), 32'(mq.size()));
    chk({tag, ".stall"}, 32'(stall),    32'(mq.size() == QD));
    chk({tag, ".ovf"},   32'(ovf),      32'(e_ovf));
  endtask

  // Everything pending plus this cycle's survivors form one age-ordered list; the head retires.
  task automatic model_step(input logic mv, input logic [AW-1:0] mrd, input logic [XLEN-1:0] md,
                            input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] ad);
    logic av_f, mv_f;
    ent_t e;
    if (mq.size() == QD) begin
      if (mv || av) e_ovf = 1'b1;
    end else begin
      av_f = av && (ard != 0);
      mv_f = mv && (mrd != 0) && !(av_f && (mrd == ard));
      if (mv_f) mq.push_back('{mrd, md});
      if (av_f) mq.push_back('{ard, ad});
    end
    if (mq.size() > 0) begin
      e     = mq.pop_front();
      e_we  = 1'b1;
      e_rd  = e.rd;
      e_dat = e.dat;
    end else begin
      e_we = 1'b0;
    end
  endtask

  task automatic cyc(input logic mv, input logic [AW-1:0] mrd, input logic [XLEN-1:0] md,
                     input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] ad,
                     input string tag);
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    model_step(mv, mrd, md, av, ard, ad);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, '0, '0, 1'b0, '0, '0, tag);
  endtask

  initial begin
    logic            mv, av, hold;
    logic [AW-1:0]   mrd, ard;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234, "alu_x5");
    idle("idle0");

    cyc(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB, "col_n1");
    chk("col_n1.rd_x3", 32'(wb_rd), 32'd3);
    chk("col_n1.cnt1", 32'(pend_cnt), 32'd1);
    idle("col_n2");
    chk("col_n2.rd_x4", 32'(wb_rd), 32'd4);
    idle("col_n3");

    cyc(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, "same_rd");
    chk("same_rd.data", wb_data, 32'h2);
    idle("same_rd_idle");

    cyc(1'b1, 5'd10, 32'hA, 1'b1, 5'd11, 32'hB, "burst1");
    cyc(1'b1, 5'd12, 32'hC, 1'b1, 5'd13, 32'hD, "burst2");
    chk("burst2.stall", 32'(stall), 32'd1);
    cyc(1'b1, 5'd14, 32'hE, 1'b1, 5'd15, 32'hF, "burst3_ovf");
    chk("burst3.ovf", 32'(ovf), 32'd1);
    idle("drain1");
    idle("drain2");

    cyc(1'b1, 5'd9, 32'h99, 1'b1, 5'd0, 32'h55, "alu_rd0");

    cyc(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, "pre_rst1");
    cyc(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, "pre_rst2");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 600; i++) begin
      mv   = ($urandom_range(0, 9) < 6);
      av   = ($urandom_range(0, 9) < 6);
      mrd  = AW'($urandom_range(0, 7));
      ard  = AW'($urandom_range(0, 7));
      hold = (mq.size() == QD) && ($urandom_range(0, 19) != 0);
      if (hold) begin
        mv = 1'b0;
        av = 1'b0;
      end
      cyc(mv, mrd, $urandom, av, ard, $urandom, "rand");
    end
    idle("final1");
    idle("final2");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
